// File: rtl/nanov_sequencer_pkg.sv
// nanov_sequencer_pkg
// Shared constants for the nanoV instruction sequencer and core decode:
// RV32I opcode values used to size an instruction's execution, funct3 shift
// codes, the NOP encoding loaded on reset, and the sequencer state encoding.
package nanov_sequencer_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/nanov_sequencer_cycle_decode.sv
// nanov_cycle_decode
// Combinational decoder giving the number of 32-clock execution cycles an
// instruction needs on the bit-serial core. Jumps, branches and shifts take
// two cycles; everything else (including unknown opcodes) takes one.
// Ports:
//   instr     in  32  instruction word
//   n_cycles  out 3   cycle count N (1 or 2)
module nanov_cycle_decode
   import nanov_sequencer_pkg::*;
(
   input  logic [31:0] instr,
   output logic [2:0]  n_cycles
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_shift;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign unused_bits = ^{instr[31:15], instr[11:7]};

   assign is_shift = ((opcode == OPC_OP_IMM) || (opcode == OPC_OP)) &&
                     ((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA));

   always_comb begin
      n_cycles = 3'd1;
      if ((opcode == OPC_JAL) || (opcode == OPC_JALR) ||
          (opcode == OPC_BRANCH) || is_shift) begin
         n_cycles = 3'd2;
      end
   end

endmodule

// File: rtl/nanov_sequencer.sv
// nanov_sequencer
// Instruction sequencer for the bit-serial nanoV core. Fetches each 32-bit
// instruction LSB-first from a serial memory port, holds it in parallel for
// the core, drives the core's counter/cycle timing and the serial pc bit,
// and forms the next PC from the core's branch flag and target.
//
// Handshake: fetch_req is high for the whole FETCH state; every clock in
// FETCH with fetch_valid=1 delivers one instruction bit on fetch_bit. There
// is no backpressure: the sequencer accepts every valid bit offered while
// fetch_req is high, and fetch_valid is ignored whenever fetch_req is low.
//
// Optional feature: define NANOV_MISALIGN_TRAP_EN to halt (trap=1) when a
// taken jump/branch has target[1]=1; otherwise target[1] is used as-is.
//
// Ports:
//   clk, rstn          core clock, synchronous active-low reset
//   fetch_req/addr     fetch outstanding / byte address (= PC)
//   fetch_bit/valid    serial instruction bit stream, LSB first
//   instr              current instruction, stable through EXEC
//   cycle, counter     execution cycle index / bit index 0..31
//   pc                 PC bit selected by counter
//   branch, target     from core: take branch, target (final clock)
//   trap               misaligned-target halt indicator
//   dbg_state          current sequencer state
module nanov_sequencer
   import nanov_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        fetch_req,
   output logic [31:0] fetch_addr,
   input  logic        fetch_bit,
   input  logic        fetch_valid,
   output logic [31:0] instr,
   output logic [2:0]  cycle,
   output logic [4:0]  counter,
   output logic        pc,
   input  logic        branch,
   input  logic [31:0] target,
   output logic        trap,
   output logic [1:0]  dbg_state
);

   seq_state_e  state_q, state_d;
   logic [30:0] fbuf_q, fbuf_d;   // bits received so far; bit 31 arrives last
   logic [4:0]  fcnt_q, fcnt_d;
   logic [31:0] instr_q, instr_d;
   logic [2:0]  cycle_q, cycle_d;
   logic [4:0]  counter_q, counter_d;
   logic [31:0] pc_q, pc_d;
   logic        taken_q, taken_d;

   logic [2:0]  n_cycles;
   logic        last_cycle;
   logic        instr_end;
   logic        fetch_done;
   logic        taken_now;
   logic        misalign_trap;
   logic [31:0] next_pc;
   logic        unused_target_lsb;

   nanov_cycle_decode u_cycle_decode (
      .instr    (instr_q),
      .n_cycles (n_cycles)
   );

   assign unused_target_lsb = target[0];

   assign last_cycle = (cycle_q == (n_cycles - 3'd1));
   assign instr_end  = (state_q == ST_EXEC) && (counter_q == 5'd31) && last_cycle;
   assign fetch_done = (state_q == ST_FETCH) && fetch_valid && (fcnt_q == 5'd31);
   // A branch flag on the final clock counts, so fold it in combinationally.
   assign taken_now  = taken_q | branch;
   assign next_pc    = taken_now ? {target[31:1], 1'b0} : (pc_q + 32'd4);

`ifdef NANOV_MISALIGN_TRAP_EN
   assign misalign_trap = taken_now && target[1];
`else
   assign misalign_trap = 1'b0;
`endif

   // State register (plus datapath registers)
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= ST_RESET;
         fbuf_q    <= '0;
         fcnt_q    <= '0;
         instr_q   <= NOP_INSTR;
         cycle_q   <= '0;
         counter_q <= '0;
         pc_q      <= RESET_PC;
         taken_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         fbuf_q    <= fbuf_d;
         fcnt_q    <= fcnt_d;
         instr_q   <= instr_d;
         cycle_q   <= cycle_d;
         counter_q <= counter_d;
         pc_q      <= pc_d;
         taken_q   <= taken_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH: if (fetch_done) state_d = ST_EXEC;
         ST_EXEC:  if (instr_end) state_d = misalign_trap ? ST_HALT : ST_FETCH;
`ifdef NANOV_MISALIGN_TRAP_EN
         ST_HALT:  state_d = ST_HALT;
`else
         ST_HALT:  state_d = ST_RESET;
`endif
         default:  state_d = ST_RESET;
      endcase
   end

   // Datapath next values
   always_comb begin
      fbuf_d    = fbuf_q;
      fcnt_d    = fcnt_q;
      instr_d   = instr_q;
      cycle_d   = cycle_q;
      counter_d = counter_q;
      pc_d      = pc_q;
      taken_d   = taken_q;
      unique case (state_q)
         ST_FETCH: begin
            if (fetch_valid) begin
               fbuf_d = {fetch_bit, fbuf_q[30:1]};
               fcnt_d = fcnt_q + 5'd1;   // wraps to 0 on the 32nd bit
               if (fcnt_q == 5'd31) begin
                  instr_d   = {fetch_bit, fbuf_q};
                  counter_d = 5'd0;
                  cycle_d   = 3'd0;
                  taken_d   = 1'b0;
               end
            end
         end
         ST_EXEC: begin
            counter_d = counter_q + 5'd1;
            if (branch) taken_d = 1'b1;
            if ((counter_q == 5'd31) && !last_cycle) cycle_d = cycle_q + 3'd1;
            if (instr_end) begin
               taken_d   = 1'b0;
               cycle_d   = 3'd0;
               counter_d = 5'd0;
               if (!misalign_trap) pc_d = next_pc;
            end
         end
         default: begin
         end
      endcase
   end

   // Outputs
   always_comb begin
      fetch_req  = (state_q == ST_FETCH);
`ifdef NANOV_MISALIGN_TRAP_EN
      trap       = (state_q == ST_HALT);
`else
      trap       = 1'b0;
`endif
      fetch_addr = pc_q;
      instr      = instr_q;
      cycle      = cycle_q;
      counter    = counter_q;
      pc         = pc_q[counter_q];
      dbg_state  = state_q;
   end

endmodule
